// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready/data handshake bundle for the skid register stage
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register stage with flush, halt and stall counter
module pipe_skid_reg #(
    parameter int WIDTH      = 32,
    parameter int FLUSH_ZERO = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 hlt,
    input  logic                 clr_cnt,
    pipe_skid_reg_if.slave       in_if,
    pipe_skid_reg_if.master      out_if,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic xfer_out;

    // in_ready looks only at registered state and hlt so no combinational path from out_ready.
    assign in_ready  = (state_q != ST_FULL) && !hlt;
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_if.valid && in_ready;
    assign xfer_out  = out_valid && out_if.ready;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_q;
    assign occupancy    = state_q;
    assign stall_cnt    = cnt_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = ST_EMPTY;
            if (FLUSH_ZERO != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (accept && xfer_out) begin
                        main_d = in_if.data;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_if.data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Skid entry moves forward; in_ready is low so nothing new lands here.
                    if (xfer_out) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_if.ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - vector-table bench for pipe_skid_reg, zeroing and retaining flush variants
module tb_pipe_skid_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       hlt = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic [1:0] occ_a, occ_b;
    logic [2:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_skid_reg_if #(.WIDTH(8)) in_a ();
    pipe_skid_reg_if #(.WIDTH(8)) out_a ();
    pipe_skid_reg_if #(.WIDTH(8)) in_b ();
    pipe_skid_reg_if #(.WIDTH(8)) out_b ();

    assign in_a.valid  = in_valid;
    assign in_a.data   = in_data;
    assign out_a.ready = out_ready;
    assign in_b.valid  = in_valid;
    assign in_b.data   = in_data;
    assign out_b.ready = out_ready;

    pipe_skid_reg #(.WIDTH(8), .FLUSH_ZERO(1), .CNT_W(3)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .hlt       (hlt),
        .clr_cnt   (clr_cnt),
        .in_if     (in_a),
        .out_if    (out_a),
        .occupancy (occ_a),
        .stall_cnt (cnt_a)
    );

    pipe_skid_reg #(.WIDTH(8), .FLUSH_ZERO(0), .CNT_W(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .hlt       (hlt),
        .clr_cnt   (clr_cnt),
        .in_if     (in_b),
        .out_if    (out_b),
        .occupancy (occ_b),
        .stall_cnt (cnt_b)
    );

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       hlt;
        logic       clr;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic [1:0] occ;
        logic [7:0] od_a;
        logic [7:0] od_b;
        logic       ir;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic h, input logic c,
                       input logic iv, input logic [7:0] d, input logic o,
                       input logic [1:0] occ, input logic [7:0] oda, input logic [7:0] odb,
                       input logic ir, input logic [2:0] cnt);
        vec_t v;
        v.rst_n = r; v.flush = f; v.hlt = h; v.clr = c; v.iv = iv; v.d = d; v.ordy = o;
        v.occ = occ; v.od_a = oda; v.od_b = odb; v.ir = ir; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // rst f  h  c  iv d      o   occ od_a   od_b   ir cnt
        add(0, 0, 0, 0, 1, 8'hA5, 1,  0, 8'h00, 8'h00, 1, 0);
        add(0, 0, 0, 0, 1, 8'hA5, 1,  0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 0, 0, 1, 8'h01, 1,  1, 8'h01, 8'h01, 1, 0);
        add(1, 0, 0, 0, 1, 8'h02, 1,  1, 8'h02, 8'h02, 1, 0);
        add(1, 0, 0, 0, 1, 8'h03, 1,  1, 8'h03, 8'h03, 1, 0);
        add(1, 0, 0, 0, 1, 8'h04, 1,  1, 8'h04, 8'h04, 1, 0);
        add(1, 0, 0, 0, 0, 8'h00, 1,  0, 8'h04, 8'h04, 1, 0);
        add(1, 0, 0, 0, 1, 8'h11, 0,  1, 8'h11, 8'h11, 1, 0);
        add(1, 0, 0, 0, 1, 8'h22, 0,  2, 8'h11, 8'h11, 0, 1);
        add(1, 0, 0, 0, 1, 8'h33, 0,  2, 8'h11, 8'h11, 0, 2);
        add(1, 0, 0, 0, 0, 8'h00, 1,  1, 8'h22, 8'h22, 1, 2);
        add(1, 0, 0, 0, 0, 8'h00, 1,  0, 8'h22, 8'h22, 1, 2);
        add(1, 0, 0, 1, 0, 8'h00, 1,  0, 8'h22, 8'h22, 1, 0);
        add(1, 0, 0, 0, 1, 8'h44, 0,  1, 8'h44, 8'h44, 1, 0);
        add(1, 0, 0, 0, 1, 8'h55, 0,  2, 8'h44, 8'h44, 0, 1);
        add(1, 0, 1, 0, 1, 8'h66, 1,  1, 8'h55, 8'h55, 0, 1);
        add(1, 0, 1, 0, 1, 8'h77, 1,  0, 8'h55, 8'h55, 0, 1);
        add(1, 0, 1, 0, 1, 8'h77, 1,  0, 8'h55, 8'h55, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00, 1,  0, 8'h55, 8'h55, 1, 1);
        add(1, 0, 0, 0, 1, 8'h81, 0,  1, 8'h81, 8'h81, 1, 1);
        add(1, 0, 0, 0, 1, 8'h82, 0,  2, 8'h81, 8'h81, 0, 2);
        add(1, 1, 0, 0, 1, 8'h99, 1,  0, 8'h00, 8'h81, 1, 2);
        add(1, 0, 0, 0, 0, 8'h00, 1,  0, 8'h00, 8'h81, 1, 2);
        add(1, 0, 0, 1, 1, 8'hA1, 0,  1, 8'hA1, 8'hA1, 1, 0);
        for (int i = 1; i <= 10; i++)
            add(1, 0, 0, 0, 0, 8'h00, 0, 1, 8'hA1, 8'hA1, 1, (i > 7) ? 3'd7 : 3'(i));
        add(1, 0, 0, 1, 0, 8'h00, 0,  1, 8'hA1, 8'hA1, 1, 0);
        add(1, 0, 0, 0, 0, 8'h00, 0,  1, 8'hA1, 8'hA1, 1, 1);
        add(1, 0, 0, 0, 1, 8'hB1, 0,  2, 8'hA1, 8'hA1, 0, 2);
        add(0, 1, 0, 1, 1, 8'hC3, 1,  0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 0, 0, 0, 8'h00, 1,  0, 8'h00, 8'h00, 1, 0);
        add(1, 0, 0, 0, 1, 8'hD1, 1,  1, 8'hD1, 8'hD1, 1, 0);
        add(1, 1, 0, 0, 1, 8'hD2, 1,  0, 8'h00, 8'hD1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; flush = vecs[i].flush; hlt = vecs[i].hlt;
            clr_cnt = vecs[i].clr; in_valid = vecs[i].iv; in_data = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d occupancy", i), 32'(occ_a), 32'(vecs[i].occ));
            chk($sformatf("v%0d out_valid", i), 32'(out_a.valid), 32'(vecs[i].occ != 2'd0));
            chk($sformatf("v%0d out_data", i), 32'(out_a.data), 32'(vecs[i].od_a));
            chk($sformatf("v%0d in_ready", i), 32'(in_a.ready), 32'(vecs[i].ir));
            chk($sformatf("v%0d stall_cnt", i), 32'(cnt_a), 32'(vecs[i].cnt));
            chk($sformatf("v%0d keep occupancy", i), 32'(occ_b), 32'(vecs[i].occ));
            chk($sformatf("v%0d keep out_data", i), 32'(out_b.data), 32'(vecs[i].od_b));
        end

        // in_ready must not react combinationally to out_ready, only to hlt
        rst_n = 1'b1; flush = 1'b0; hlt = 1'b0; clr_cnt = 1'b0;
        in_valid = 1'b1; in_data = 8'hE1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_data = 8'hE2;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("full in_ready vs out_ready", 32'(in_a.ready), 32'd0);
        chk("full out_data", 32'(out_a.data), 32'hE1);
        @(posedge clk); #1;
        chk("drain to one", 32'(occ_a), 32'd1);
        chk("drain data", 32'(out_a.data), 32'hE2);
        out_ready = 1'b0;
        #1;
        chk("one in_ready with out_ready low", 32'(in_a.ready), 32'd1);
        hlt = 1'b1;
        #1;
        chk("hlt gates in_ready", 32'(in_a.ready), 32'd0);
        hlt = 1'b0;
        #1;
        chk("hlt release in_ready", 32'(in_a.ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..256.
REQ-002 Parameter FLUSH_ZERO, default 1: 1 = payload registers cleared on flush; 0 = payload retained, valid only cleared.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held entries and any same-cycle input.
REQ-007 hlt  input  1  halt; blocks new input acceptance while the output continues to drain.
REQ-008 clr_cnt  input  1  synchronous clear of stall_cnt.
REQ-009 in_valid  input  1  upstream payload valid.
REQ-010 in_data  input  WIDTH  upstream payload.
REQ-011 in_ready  output  1  stage can accept; depends only on registered state and hlt, never on out_ready.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_data  output  WIDTH  downstream payload, driven directly from the main register.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 occupancy  output  2  entries held: 0, 1 or 2.
REQ-016 stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-017 Storage: main register (drives out_data) and skid register; FIFO order always preserved.
REQ-018 Accept = in_valid & in_ready; Release = out_valid & out_ready.
REQ-019 in_ready = (occupancy != 2) & ~hlt.
REQ-020 out_valid = (occupancy != 0).
REQ-021 EMPTY(0): Accept -> ONE, main <= in_data.
REQ-022 ONE(1): Accept only -> FULL, skid <= in_data; Release only -> EMPTY; Accept and Release -> ONE, main <= in_data; neither -> hold.
REQ-023 FULL(2): Release -> ONE, main <= skid; no Release -> hold. Accept is impossible because in_ready = 0.
REQ-024 Latency: a payload accepted in cycle N appears on out_data with out_valid in cycle N+1 when the stage was EMPTY, or when it was ONE with a concurrent Release.
REQ-025 Throughput: one transfer per cycle sustained while out_ready = 1.
REQ-026 Flush (priority over all but reset): next occupancy = 0; same-cycle Accept and Release data are discarded; main and skid <= 0 if FLUSH_ZERO = 1, else unchanged.
REQ-027 hlt during FULL or ONE: stored entries still drain on Release; no new Accept occurs.
REQ-028 stall_cnt increments each cycle with out_valid & ~out_ready and saturates at 2^CNT_W-1.
REQ-029 clr_cnt has priority over increment; flush does not affect stall_cnt.
REQ-030 Payload registers are never written with in_data unless Accept is true.

Reset
REQ-031 rst_n = 0 at a posedge sets: occupancy = 0, out_valid = 0, main = 0, skid = 0, stall_cnt = 0. in_ready then follows REQ-019 (1 unless hlt).
REQ-032 Reset overrides flush, clr_cnt and any handshake in the same cycle; a reset during FULL loses both entries.
REQ-033 Outputs are defined from the first posedge with rst_n = 0; nothing is updated asynchronously.

Verification
REQ-034 Reset with in_valid = 1, in_data = 0xA5 -> after release, occupancy = 0, out_valid = 0, out_data = 0, in_ready = 1, stall_cnt = 0.
REQ-035 Stream 1,2,3,4 with out_ready = 1 continuously -> out_data 1,2,3,4 on consecutive cycles, one cycle after each accept, occupancy never exceeds 1.
REQ-036 out_ready = 0, push 0x11 then 0x22 -> occupancy = 2, in_ready = 0, out_data = 0x11. Then out_ready = 1 -> 0x11, then 0x22, then EMPTY.
REQ-037 FULL with hlt = 1 and out_ready = 1 -> drains 2 -> 1 -> 0; in_ready remains 0 until hlt = 0.
REQ-038 FULL plus flush with in_valid = 1 (FLUSH_ZERO = 1) -> next cycle occupancy = 0, out_data = 0, incoming data not captured, stall_cnt unchanged.
REQ-039 CNT_W = 3, hold out_valid with out_ready = 0 for 10 cycles -> stall_cnt saturates at 7; clr_cnt -> 0 next cycle.
